// File: rtl/seg_disp_counter.sv
// Two-digit multiplexed 7-segment display of a 0..15 count in decimal.
// Count is sampled once per frame so both digits always come from one value.
module seg_disp_counter #(
   parameter int SCAN_DIV    = 50000,
   parameter bit SEG_ACT_LOW = 1'b1,
   parameter bit SEL_ACT_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] pi_cnt,
   input  logic       pi_en,
   output logic [7:0] po_seg,
   output logic [1:0] po_sel
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
   localparam logic [7:0] SEG_INV = {8{SEG_ACT_LOW}};
   localparam logic [1:0] SEL_INV = {2{SEL_ACT_LOW}};
   localparam logic [7:0] SEG_OFF = 8'h00 ^ SEG_INV;
   localparam logic [1:0] SEL_OFF = 2'b00 ^ SEL_INV;
   localparam logic [1:0] SEL_UNITS = 2'b01 ^ SEL_INV;
   localparam logic [1:0] SEL_TENS = 2'b10 ^ SEL_INV;

   typedef enum logic {
      TENS,
      UNITS
   } digit_t;

   logic [DW-1:0] div_cnt;
   logic          tick;
   digit_t        digit;
   logic [3:0]    cnt_r;
   logic [3:0]    units_v;
   logic [7:0]    units_seg;
   logic [7:0]    tens_seg;

   function automatic logic [6:0] digit_pat(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   assign tick = (div_cnt == DIV_MAX);

   // Input is at most 15, so tens is 0 or 1 and units is a single subtract.
   always_comb begin
      units_v   = (pi_cnt >= 4'd10) ? pi_cnt - 4'd10 : pi_cnt;
      units_seg = {1'b0, digit_pat(units_v)} ^ SEG_INV;
      tens_seg  = ((cnt_r >= 4'd10) ? 8'h06 : 8'h00) ^ SEG_INV;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         digit   <= TENS;
         cnt_r   <= 4'd0;
         po_seg  <= SEG_OFF;
         po_sel  <= SEL_OFF;
      end else begin
         if (tick) div_cnt <= '0;
         else      div_cnt <= div_cnt + DW'(1);

         if (tick) begin
            case (digit)
               TENS: begin
                  digit <= UNITS;
                  cnt_r <= pi_cnt;
               end
               UNITS:   digit <= TENS;
               default: digit <= TENS;
            endcase
         end

         // Outputs hold between ticks, so a re-enable stays dark until one.
         if (!pi_en) begin
            po_seg <= SEG_OFF;
            po_sel <= SEL_OFF;
         end else if (tick) begin
            if (digit == TENS) begin
               po_seg <= units_seg;
               po_sel <= SEL_UNITS;
            end else begin
               po_seg <= tens_seg;
               po_sel <= SEL_TENS;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_disp_counter.sv
// Bench for seg_disp_counter: random count/enable/reset stimulus against
// a frame-level decimal display model, checked through a scoreboard queue.
module tb_seg_disp_counter;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] pi_cnt = 4'd0;
   logic       pi_en = 1'b1;
   logic [7:0] po_seg;
   logic [1:0] po_sel;

   seg_disp_counter #(
      .SCAN_DIV   (SD),
      .SEG_ACT_LOW(1'b1),
      .SEL_ACT_LOW(1'b1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .pi_cnt(pi_cnt),
      .pi_en (pi_en),
      .po_seg(po_seg),
      .po_sel(po_sel)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] seg;
      logic [1:0] sel;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_on = 1'b0;

   // Model state: edges since reset release, value latched for the frame.
   int         n_edges = 0;
   int         frame_val = 0;
   exp_t       cur = '{seg: 8'hFF, sel: 2'b11};
   logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   task automatic check(input string name, input exp_t got, input exp_t want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: seg=%h sel=%b, wanted seg=%h sel=%b",
                  name, got.seg, got.sel, want.seg, want.sel);
      end
   endtask

   always @(posedge clk) begin
      if (mon_on) begin
         #1;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard: empty queue at time %0t", $time);
         end else begin
            check("cycle", '{seg: po_seg, sel: po_sel}, exp_q.pop_front());
         end
      end
   end

   // Model of the next rising edge given inputs held across it.
   task automatic model_edge(input int v, input bit en);
      int   t;
      exp_t shown;
      n_edges++;
      t = n_edges / SD;
      if (n_edges % SD == 0) begin
         if (t % 2 == 1) begin
            frame_val = v;
            shown.seg = ~{1'b0, seg_tab[v % 10]};
            shown.sel = 2'b10;
         end else begin
            shown.seg = (frame_val / 10 == 0) ? 8'hFF : ~{1'b0, seg_tab[1]};
            shown.sel = 2'b01;
         end
         if (en) cur = shown;
      end
      if (!en) cur = '{seg: 8'hFF, sel: 2'b11};
   endtask

   task automatic step(input int v, input bit en, input bit rst_val);
      @(negedge clk);
      pi_cnt = 4'(v);
      pi_en  = en;
      #2;
      if (rst && !rst_val) begin
         rst = 1'b0;
         #1;
         check("async_rst", '{seg: po_seg, sel: po_sel}, '{seg: 8'hFF, sel: 2'b11});
      end else begin
         rst = rst_val;
      end
      if (!rst_val) begin
         n_edges   = 0;
         frame_val = 0;
         cur       = '{seg: 8'hFF, sel: 2'b11};
      end else begin
         model_edge(v, en);
      end
      exp_q.push_back(cur);
      mon_on = 1'b1;
   endtask

   initial begin
      repeat (10) @(negedge clk);
      check("reset_state", '{seg: po_seg, sel: po_sel}, '{seg: 8'hFF, sel: 2'b11});

      for (int i = 0; i < 12; i++) step(7, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(13, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) step(12, 1'b1, 1'b1);
      for (int i = 0; i < 14; i++) step(5, 1'b1, 1'b1);
      step(15, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(15, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) step(15, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) step(0, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) step(9, 1'b1, 1'b1);
      step(9, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(9, 1'b1, 1'b1);

      for (int i = 0; i < 400; i++) begin
         int  v;
         bit  en;
         bit  r;
         v  = $urandom_range(0, 15);
         en = ($urandom_range(0, 9) != 0);
         r  = ($urandom_range(0, 59) != 0);
         step(v, en, r);
      end
      step(3, 1'b1, 1'b1);

      @(posedge clk);
      #2;
      mon_on = 1'b0;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d left in queue, wanted 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
